// File: rtl/wb_sram.sv
// Wishbone classic single-port SRAM slave with configurable wait states.
// Requests are accepted only in IDLE. The array access happens on the edge
// that enters RESP, and ack/err is high for the single cycle spent in RESP.
// Addresses at or beyond DEPTH terminate with err and never touch the array.
module wb_sram #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 16,
  parameter int DEPTH       = 16384,
  parameter int WAIT_STATES = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ADDR_WIDTH-1:0]   wb_adr_i,
  input  logic [DATA_WIDTH-1:0]   wb_dat_i,
  input  logic [DATA_WIDTH/8-1:0] wb_sel_i,
  input  logic                    wb_we_i,
  input  logic                    wb_stb_i,
  input  logic                    wb_cyc_i,
  output logic [DATA_WIDTH-1:0]   wb_dat_o,
  output logic                    wb_ack_o,
  output logic                    wb_err_o
);

  localparam int                  LP_LANES   = DATA_WIDTH / 8;
  localparam int                  LP_IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] LP_DEPTH   = (ADDR_WIDTH + 1)'(DEPTH);
  localparam bit                  LP_NO_WAIT = (WAIT_STATES == 0);
  localparam logic [2:0]          LP_WS_LOAD = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                  r_state;
  logic [2:0]              r_cnt;
  logic [ADDR_WIDTH-1:0]   r_adr;
  logic [DATA_WIDTH-1:0]   r_dat;
  logic [LP_LANES-1:0]     r_sel;
  logic                    r_we;
  logic                    r_ack;
  logic                    r_err;
  logic [DATA_WIDTH-1:0]   r_dat_o;
  logic [DATA_WIDTH-1:0]   r_mem [DEPTH];

  logic                    w_req;
  logic                    w_enter_resp;
  logic [ADDR_WIDTH-1:0]   w_op_adr;
  logic [DATA_WIDTH-1:0]   w_op_dat;
  logic [LP_LANES-1:0]     w_op_sel;
  logic                    w_op_we;
  logic                    w_in_range;
  logic [LP_IDX_W-1:0]     w_idx;
  logic                    w_mem_we;

  assign w_req = wb_cyc_i & wb_stb_i;

  // With no wait states the access happens on the capture edge itself, so the
  // operands must come straight from the bus; otherwise use the captured copy.
  assign w_op_adr = (r_state == IDLE) ? wb_adr_i : r_adr;
  assign w_op_dat = (r_state == IDLE) ? wb_dat_i : r_dat;
  assign w_op_sel = (r_state == IDLE) ? wb_sel_i : r_sel;
  assign w_op_we  = (r_state == IDLE) ? wb_we_i  : r_we;

  // The edge that moves the FSM into RESP; an abort (cyc low) wins over count 0.
  assign w_enter_resp = ((r_state == IDLE) && w_req && LP_NO_WAIT) ||
                        ((r_state == WAIT) && wb_cyc_i && (r_cnt == 3'd0));

  assign w_in_range = ({1'b0, w_op_adr} < LP_DEPTH);
  assign w_idx      = w_op_adr[LP_IDX_W-1:0];

  // Gated by rst_n so a request held on the bus during reset cannot write.
  assign w_mem_we = rst_n & w_enter_resp & w_op_we & w_in_range;

  // Byte-lane write port of the array; contents are intentionally never reset.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      for (int i = 0; i < LP_LANES; i++) begin
        if (w_op_sel[i]) begin
          r_mem[w_idx][i*8 +: 8] <= w_op_dat[i*8 +: 8];
        end
      end
    end
  end

  // Transaction FSM with request capture, wait counter and registered termination.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= 3'd0;
      r_adr   <= '0;
      r_dat   <= '0;
      r_sel   <= '0;
      r_we    <= 1'b0;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_dat_o <= '0;
    end else begin
      r_ack <= 1'b0;
      r_err <= 1'b0;

      case (r_state)
        IDLE: begin
          if (w_req) begin
            r_adr <= wb_adr_i;
            r_dat <= wb_dat_i;
            r_sel <= wb_sel_i;
            r_we  <= wb_we_i;
            if (LP_NO_WAIT) begin
              r_state <= RESP;
            end else begin
              r_state <= WAIT;
              r_cnt   <= LP_WS_LOAD;
            end
          end
        end
        WAIT: begin
          if (!wb_cyc_i) begin
            r_state <= IDLE;
          end else if (r_cnt == 3'd0) begin
            r_state <= RESP;
          end else begin
            r_cnt <= r_cnt - 3'd1;
          end
        end
        RESP: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase

      // Termination and read data are produced on the edge entering RESP.
      if (w_enter_resp) begin
        if (w_in_range) begin
          r_ack <= 1'b1;
          if (!w_op_we) begin
            r_dat_o <= r_mem[w_idx];
          end
        end else begin
          r_err   <= 1'b1;
          r_dat_o <= '0;
        end
      end
    end
  end

  assign wb_dat_o = r_dat_o;
  assign wb_ack_o = r_ack;
  assign wb_err_o = r_err;

endmodule

// File: tb/tb_wb_sram.sv
// Scoreboard bench for wb_sram: three instances with different wait-state and
// depth settings share the bus; each has its own cyc line. Stimulus pushes the
// expected termination (cycle, ack/err, read data); a negedge monitor pops it.
module tb_wb_sram;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] adr;
  logic [31:0] wdat;
  logic [3:0]  sel;
  logic        we;
  logic        stb;
  logic [2:0]  cyc;
  logic [2:0]  ack;
  logic [2:0]  err;
  logic [31:0] rdat [3];

  int cyc_cnt = 0;
  int checks  = 0;
  int errors  = 0;
  int tag_n   = 0;

  typedef struct {
    int          dut;
    int          cyc;
    bit          err;
    bit          rd;
    logic [31:0] dat;
    int          tag;
  } exp_t;

  exp_t sb_q[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  wb_sram #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .DEPTH(1024), .WAIT_STATES(0)) u_d0 (
    .clk(clk), .rst_n(rst_n), .wb_adr_i(adr), .wb_dat_i(wdat), .wb_sel_i(sel),
    .wb_we_i(we), .wb_stb_i(stb), .wb_cyc_i(cyc[0]),
    .wb_dat_o(rdat[0]), .wb_ack_o(ack[0]), .wb_err_o(err[0])
  );

  wb_sram #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .DEPTH(16384), .WAIT_STATES(3)) u_d1 (
    .clk(clk), .rst_n(rst_n), .wb_adr_i(adr), .wb_dat_i(wdat), .wb_sel_i(sel),
    .wb_we_i(we), .wb_stb_i(stb), .wb_cyc_i(cyc[1]),
    .wb_dat_o(rdat[1]), .wb_ack_o(ack[1]), .wb_err_o(err[1])
  );

  wb_sram #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .DEPTH(1024), .WAIT_STATES(5)) u_d2 (
    .clk(clk), .rst_n(rst_n), .wb_adr_i(adr), .wb_dat_i(wdat), .wb_sel_i(sel),
    .wb_we_i(we), .wb_stb_i(stb), .wb_cyc_i(cyc[2]),
    .wb_dat_o(rdat[2]), .wb_ack_o(ack[2]), .wb_err_o(err[2])
  );

  function automatic int ws_of(input int d);
    case (d)
      0:       return 0;
      1:       return 3;
      default: return 5;
    endcase
  endfunction

  // Monitor: every termination must match the oldest expectation exactly.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < 3; k++) begin
        if (ack[k] && err[k]) begin
          checks++;
          errors++;
          $display("FAIL both_term dut%0d cycle=%0d: ack=1 err=1, required at most one", k, cyc_cnt);
        end
        if (ack[k] || err[k]) begin
          checks++;
          if (sb_q.size() == 0 || sb_q[0].dut != k) begin
            errors++;
            $display("FAIL unexpected_term dut%0d cycle=%0d: got ack=%0b err=%0b, required no termination",
                     k, cyc_cnt, ack[k], err[k]);
          end else begin
            exp_t e;
            e = sb_q.pop_front();
            if (e.cyc != cyc_cnt || e.err != err[k] || (e.rd && rdat[k] !== e.dat)) begin
              errors++;
              $display("FAIL term_t%0d dut%0d: got cycle=%0d err=%0b dat=%08h, required cycle=%0d err=%0b dat=%08h%s",
                       e.tag, k, cyc_cnt, err[k], rdat[k], e.cyc, e.err, e.dat, e.rd ? "" : " (dat not checked)");
            end else begin
              $display("PASS term_t%0d dut%0d cycle=%0d %s %s dat=%08h",
                       e.tag, k, cyc_cnt, e.rd ? "read" : "write", e.err ? "err" : "ack", rdat[k]);
            end
          end
        end
      end
      if (sb_q.size() > 0 && sb_q[0].cyc < cyc_cnt) begin
        exp_t e;
        e = sb_q.pop_front();
        checks++;
        errors++;
        $display("FAIL timeout_t%0d dut%0d: no termination by cycle %0d, required at cycle %0d",
                 e.tag, e.dut, cyc_cnt, e.cyc);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %08h, required %08h", nm, act, req);
    end else begin
      $display("PASS %s value=%08h", nm, act);
    end
  endtask

  // One complete bus transaction; expectation is queued before the request edge.
  task automatic xfer(input int d, input bit w, input logic [15:0] a, input logic [31:0] dt,
                      input logic [3:0] s, input bit e_err, input logic [31:0] e_dat);
    exp_t e;
    @(negedge clk);
    adr    = a;
    wdat   = dt;
    sel    = s;
    we     = w;
    stb    = 1'b1;
    cyc    = 3'b000;
    cyc[d] = 1'b1;
    e.dut  = d;
    e.cyc  = cyc_cnt + 1 + ws_of(d);
    e.err  = e_err;
    e.rd   = !w;
    e.dat  = e_dat;
    e.tag  = tag_n;
    tag_n++;
    sb_q.push_back(e);
    repeat (ws_of(d) + 1) @(posedge clk);
    #1;
    stb = 1'b0;
    cyc = 3'b000;
    @(posedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    adr   = '0;
    wdat  = '0;
    sel   = '0;
    we    = 1'b0;
    stb   = 1'b0;
    cyc   = 3'b000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("reset_dat_dut%0d", k), rdat[k], 32'h0);
      chk($sformatf("reset_term_dut%0d", k), {30'b0, ack[k], err[k]}, 32'h0);
    end
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Zero wait states: basic write/read, byte lanes, empty sel.
    xfer(0, 1'b1, 16'h0010, 32'hDEADBEEF, 4'hF, 1'b0, 32'h0);
    xfer(0, 1'b0, 16'h0010, 32'h0,        4'hF, 1'b0, 32'hDEADBEEF);
    xfer(0, 1'b1, 16'h0020, 32'h11223344, 4'hF, 1'b0, 32'h0);
    xfer(0, 1'b1, 16'h0020, 32'hAABBCCDD, 4'h5, 1'b0, 32'h0);
    xfer(0, 1'b0, 16'h0020, 32'h0,        4'h0, 1'b0, 32'h11BB33DD);
    xfer(0, 1'b1, 16'h0020, 32'hFFFFFFFF, 4'h0, 1'b0, 32'h0);
    xfer(0, 1'b0, 16'h0020, 32'h0,        4'hF, 1'b0, 32'h11BB33DD);

    // Depth boundary: last word works, DEPTH errors and must not alias to word 0.
    xfer(0, 1'b1, 16'h0000, 32'h00000077, 4'hF, 1'b0, 32'h0);
    xfer(0, 1'b1, 16'd1023, 32'hCAFEF00D, 4'hF, 1'b0, 32'h0);
    xfer(0, 1'b0, 16'd1023, 32'h0,        4'hF, 1'b0, 32'hCAFEF00D);
    xfer(0, 1'b1, 16'd1024, 32'h5A5A5A5A, 4'hF, 1'b1, 32'h0);
    xfer(0, 1'b0, 16'h0020, 32'h0,        4'hF, 1'b0, 32'h11BB33DD);
    xfer(0, 1'b0, 16'd1024, 32'h0,        4'hF, 1'b1, 32'h0);
    xfer(0, 1'b0, 16'h0000, 32'h0,        4'hF, 1'b0, 32'h00000077);

    // Three wait states: latency of four cycles with cyc/stb held.
    xfer(1, 1'b1, 16'h0010, 32'h01020304, 4'hF, 1'b0, 32'h0);
    xfer(1, 1'b0, 16'h0010, 32'h0,        4'hF, 1'b0, 32'h01020304);

    // Five wait states: abort by dropping cyc two cycles into the wait.
    xfer(2, 1'b1, 16'h0030, 32'h0BADF00D, 4'hF, 1'b0, 32'h0);
    xfer(2, 1'b0, 16'h0030, 32'h0,        4'hF, 1'b0, 32'h0BADF00D);
    @(negedge clk);
    adr = 16'h0030; wdat = 32'h00000001; sel = 4'hF; we = 1'b1; stb = 1'b1; cyc = 3'b100;
    repeat (2) @(posedge clk);
    #1;
    cyc = 3'b000;
    repeat (8) @(posedge clk);
    stb = 1'b0;
    @(negedge clk);
    chk("abort_dat_hold", rdat[2], 32'h0BADF00D);
    xfer(2, 1'b0, 16'h0030, 32'h0,        4'hF, 1'b0, 32'h0BADF00D);

    // Reset asserted between edges during the wait of a write.
    xfer(2, 1'b1, 16'h0040, 32'h12345678, 4'hF, 1'b0, 32'h0);
    xfer(2, 1'b0, 16'h0040, 32'h0,        4'hF, 1'b0, 32'h12345678);
    @(negedge clk);
    adr = 16'h0040; wdat = 32'hFFFFFFFF; sel = 4'hF; we = 1'b1; stb = 1'b1; cyc = 3'b100;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_dat", rdat[2], 32'h0);
    chk("rst_mid_term", {30'b0, ack[2], err[2]}, 32'h0);
    stb = 1'b0;
    cyc = 3'b000;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    xfer(2, 1'b0, 16'h0040, 32'h0,        4'hF, 1'b0, 32'h12345678);

    repeat (10) @(posedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL pending_terms: got %0d outstanding, required 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
